obstacle_pool: RTL

Parametrised successor to the fixed two-slot obstacle generator. Manages NUM_OBS independent obstacle slots that scroll left at a ramping speed. Spawns new obstacles from the shared LFSR with randomised gaps, and exports per-slot position, type and active flag to the obs_render/obs_rom instances and the AI controller. Sits between the game-tick source in graphics_top and the renderers, gated by player_controller's game_start_pulse and game_frozen.

---
 rtl/obstacle_pool.sv | 107 ++++++++++
 1 files changed

// File: rtl/obstacle_pool.sv
// obstacle_pool: NUM_OBS scrolling obstacle slots with LFSR-driven spawning and speed ramp
module obstacle_pool #(
    parameter int NUM_OBS    = 3,
    parameter int CONV       = 2,
    parameter int SPAWN_X    = 160,
    parameter int INIT_GAP   = 30,
    parameter int MIN_GAP    = 20,
    parameter int MAX_SPEED  = 4,
    parameter int RAMP_TICKS = 600,
    localparam int POS_W     = 10 - CONV
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     game_tick,
    input  logic                     game_start,
    input  logic                     game_frozen,
    input  logic [7:0]               rng,
    output logic [NUM_OBS*POS_W-1:0] obs_pos,
    output logic [NUM_OBS*3-1:0]     obs_type,
    output logic [NUM_OBS-1:0]       obs_active,
    output logic [3:0]               speed
);
    localparam int GAP_MAX = (INIT_GAP > MIN_GAP + 31) ? INIT_GAP : MIN_GAP + 31;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam int RAMP_W  = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    logic [POS_W-1:0]  pos_q [NUM_OBS];
    logic [2:0]        type_q [NUM_OBS];
    logic [NUM_OBS-1:0] act_q;
    logic [GAP_W-1:0]  gap_q;
    logic [RAMP_W-1:0] ramp_q;
    logic [3:0]        spd_q;
    logic [NUM_OBS-1:0] spawn_sel;
    logic              do_spawn;
    logic              seen;
    logic              tick_ok;

    assign tick_ok  = game_tick && !game_frozen;
    assign do_spawn = (gap_q == '0) && !(&act_q);

    // one-hot select of the lowest slot that is free before this tick's move
    always_comb begin
        seen = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            spawn_sel[i] = !act_q[i] && !seen;
            seen = seen || !act_q[i];
        end
    end

    // slot, gap and speed state; start beats freeze beats tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                pos_q[i]  <= '1;
                type_q[i] <= '0;
            end
            act_q  <= '0;
            gap_q  <= GAP_W'(INIT_GAP);
            ramp_q <= '0;
            spd_q  <= 4'd1;
        end else if (game_start) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                pos_q[i]  <= '1;
                type_q[i] <= '0;
            end
            act_q  <= '0;
            gap_q  <= GAP_W'(INIT_GAP);
            ramp_q <= '0;
            spd_q  <= 4'd1;
        end else if (tick_ok) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (act_q[i]) begin
                    if (pos_q[i] >= POS_W'(spd_q)) begin
                        pos_q[i] <= pos_q[i] - POS_W'(spd_q);
                    end else begin
                        act_q[i]  <= 1'b0;
                        pos_q[i]  <= '1;
                        type_q[i] <= '0;
                    end
                end else if (do_spawn && spawn_sel[i]) begin
                    act_q[i]  <= 1'b1;
                    pos_q[i]  <= POS_W'(SPAWN_X);
                    type_q[i] <= rng[2:0];
                end
            end
            gap_q <= do_spawn ? GAP_W'(MIN_GAP) + GAP_W'(rng[7:3])
                   : (gap_q != '0) ? gap_q - 1'b1 : gap_q;
            if (ramp_q == RAMP_W'(RAMP_TICKS - 1)) begin
                ramp_q <= '0;
                spd_q  <= (spd_q < 4'(MAX_SPEED)) ? spd_q + 4'd1 : spd_q;
            end else begin
                ramp_q <= ramp_q + 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OBS; g++) begin : g_pack
            assign obs_pos[g*POS_W +: POS_W] = pos_q[g];
            assign obs_type[g*3 +: 3]        = type_q[g];
        end
    endgenerate

    assign obs_active = act_q;
    assign speed      = spd_q;
endmodule
